led_frame_buffer: RTL and testbench
===================================

Name: led_frame_buffer

Overview:
- Upstream stage of the badge LED PWM scanner: holds per-LED RGB intensity for the 11 ledc sources and serves one sink slot's 11 byte values per cycle to the PWM compare logic.
- Double-buffered. Writers fill the back buffer, then a commit swaps it to front only at a PWM frame boundary, so a frame is never displayed half-updated.
- Applies the per-LED logical-colour-to-sink-slot mapping at write time.
- Applies a global brightness scale at read time.

Parameters:
- NUM_LEDS, 11, number of ledc sources.
- NUM_SLOTS, 3, number of sink slots (ledrgb lines).
- COLOR_MAP, 66-bit vector, per-LED slot map. Bits [6l+5:6l] = {slot_of_red, slot_of_green, slot_of_blue}, each 2 bits. Default is the production board order: LED0 {0,1,2}, LED1 {2,1,0}, LED2 {0,1,2}, LED3 {2,1,0}, LED4 {0,1,2}, LED5 {2,1,0}, LED6 {2,1,0}, LED7 {1,0,2}, LED8 {1,0,2}, LED9 {0,1,2}, LED10 {0,1,2}.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_led  in  4  LED index, 0..NUM_LEDS-1
- wr_color  in  2  0=red, 1=green, 2=blue
- wr_value  in  8  intensity
- wr_err  out  1  one-cycle pulse: accepted write had an illegal index/colour and was dropped
- clear  in  1  pulse: zero the back buffer
- commit  in  1  pulse: request back/front swap at next frame_start
- commit_pending  out  1  swap requested, not yet done
- brightness  in  8  global scale
- frame_start  in  1  pulse from the PWM stage on the cycle its counter reloads
- rd_slot  in  2  sink slot currently being driven
- rd_values  out  88  lane l = [8l+7:8l], scaled value for LED l in rd_slot

Behaviour:
- Storage: two banks, each NUM_LEDS x NUM_SLOTS x 8 bits, indexed by physical slot. front_sel selects the displayed bank.
- Write path:
  - Phys slot = COLOR_MAP field for (wr_led, wr_color).
  - An accepted write stores wr_value into bank !front_sel at [wr_led][phys slot]; it is visible in the back bank the next cycle.
  - wr_led>=NUM_LEDS or wr_color==3: the write is accepted, nothing is stored, and wr_err pulses on the next cycle.
- FSM states IDLE, CLEAR:
  - IDLE: clear=1 moves to CLEAR with clr_idx=0.
  - CLEAR: zeroes one LED (all 3 slots) of the back bank per cycle, clr_idx 0..NUM_LEDS-1, then returns to IDLE. It takes exactly NUM_LEDS cycles.
  - clear is ignored while already in CLEAR.
- wr_ready = 1 only in IDLE, not in reset, and not in a swap cycle. It is 0 during CLEAR.
- Commit:
  - commit sets commit_pending the next cycle.
  - Swap cycle = frame_start && commit_pending && state==IDLE. On it, front_sel toggles and commit_pending clears.
  - A commit during CLEAR stays pending until CLEAR finishes and the next frame_start arrives.
  - commit and frame_start in the same cycle: no swap that cycle; the swap happens at the following frame_start.
  - The new back bank keeps its stale contents; there is no copy.
- Brightness:
  - brightness is latched into bright_q on frame_start only.
  - Lane value = (raw * (bright_q + 1)) >> 8, 16-bit product, upper byte taken. bright_q=255 gives raw unchanged; bright_q=0 gives raw>>8 = 0.
- Read:
  - rd_values is registered. rd_slot sampled in cycle N gives data from the front bank as of cycle N on rd_values in N+1.
  - rd_slot==3 yields all-zero lanes.
  - A swap in cycle N affects reads sampled from N+1.
- Reset:
  - Both banks zero, front_sel=0, state IDLE, commit_pending=0, bright_q=255, rd_values=0, wr_err=0, wr_ready=0 during reset.
  - rst mid-CLEAR or with a commit pending abandons both and applies the reset values.

Decomposition:
- Shared package led_pkg:
  - colour codes RED=0, GREEN=1, BLUE=2
  - NUM_LEDS and NUM_SLOTS constants
  - default COLOR_MAP constant
  - fsm state typedef
- The PWM scanner imports led_pkg too, so both stages agree on slot encoding.
- One natural sub-module: led_scale8, the combinational 8x8 scale of a single lane, instantiated NUM_LEDS times.

Test Plan:
- Write LED0 red=0xFF, commit, pulse frame_start, rd_slot=0 -> next cycle lane0=0xFF. Write LED1 red=0xFF, commit, frame_start, rd_slot=2 -> lane1=0xFF (mapping check).
- Write LED7 green=0x40, no commit, rd_slot=0 -> lane7=0x00. Then commit and frame_start -> rd_slot=0 gives lane7=0x40, and commit_pending drops on the swap cycle.
- brightness=0x7F with frame_start, displayed raw 0x80 -> lane=0x40. Change brightness mid-frame -> lane unchanged until the next frame_start.
- Illegal writes: wr_led=11 or wr_color=3 -> wr_err pulses 1 cycle and neither bank changes.
- clear pulse -> wr_ready low for exactly 11 cycles. A commit issued during CLEAR swaps only at the first frame_start after CLEAR, after which all lanes read 0x00 on every slot.
- Assert rst mid-CLEAR with commit pending -> commit_pending=0, rd_values=0, bright_q=255, and wr_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the badge LED frame buffer and PWM scanner:
// colour codes, array sizes, production slot map and FSM states.
package led_pkg;

    localparam int unsigned NUM_LEDS  = 11;
    localparam int unsigned NUM_SLOTS = 3;
    localparam int unsigned VAL_W     = 8;
    localparam int unsigned LED_W     = 4;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned COLOR_W   = 2;
    localparam int unsigned MAP_W     = 6 * NUM_LEDS;

    localparam logic [COLOR_W-1:0] RED   = 2'd0;
    localparam logic [COLOR_W-1:0] GREEN = 2'd1;
    localparam logic [COLOR_W-1:0] BLUE  = 2'd2;

    // Per LED {slot_of_red, slot_of_green, slot_of_blue}, LED10 down to LED0.
    localparam logic [MAP_W-1:0] DEFAULT_COLOR_MAP = {
        6'h06, 6'h06, 6'h12, 6'h12, 6'h24, 6'h24,
        6'h06, 6'h24, 6'h06, 6'h24, 6'h06
    };

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/led_scale8.sv
// Brightness scale of one lane: (raw * (scale + 1)) >> 8.
module led_scale8
    import led_pkg::*;
(
    input  logic [VAL_W-1:0] raw,
    input  logic [VAL_W-1:0] scale,
    output logic [VAL_W-1:0] scaled_c
);

    localparam int unsigned PROD_W = 2 * VAL_W;

    logic [VAL_W:0]    factor;
    logic [PROD_W-1:0] product;

    // scale+1 spans 1..256, so 255 passes raw through unchanged.
    assign factor   = {1'b0, scale} + (VAL_W+1)'(1);
    assign product  = PROD_W'(raw) * PROD_W'(factor);
    assign scaled_c = VAL_W'(product >> VAL_W);

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered per-LED RGB store: slot-mapped writes into the back bank,
// frame-aligned swap, and brightness-scaled registered reads of one sink slot.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int unsigned             NUM_LEDS  = led_pkg::NUM_LEDS,
    parameter int unsigned             NUM_SLOTS = led_pkg::NUM_SLOTS,
    parameter logic [6*NUM_LEDS-1:0]   COLOR_MAP = led_pkg::DEFAULT_COLOR_MAP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LED_W-1:0]          wr_led,
    input  logic [COLOR_W-1:0]        wr_color,
    input  logic [VAL_W-1:0]          wr_value,
    output logic                      wr_err,
    input  logic                      clear,
    input  logic                      commit,
    output logic                      commit_pending,
    input  logic [VAL_W-1:0]          brightness,
    input  logic                      frame_start,
    input  logic [SLOT_W-1:0]         rd_slot,
    output logic [NUM_LEDS*VAL_W-1:0] rd_values
);

    logic [VAL_W-1:0] bank [2][NUM_LEDS][NUM_SLOTS];

    fsm_state_t       state;
    logic [LED_W-1:0] clr_idx;
    logic             front_sel;
    logic             back_sel;
    logic [VAL_W-1:0] bright_q;

    logic              swap;
    logic              wr_fire;
    logic              wr_legal;
    logic [SLOT_W-1:0] wr_phys;
    int unsigned       map_shift;

    logic [VAL_W-1:0] raw    [NUM_LEDS];
    logic [VAL_W-1:0] scaled [NUM_LEDS];

    assign back_sel = ~front_sel;
    assign swap     = frame_start && commit_pending && (state == ST_IDLE);
    assign wr_ready = !rst && (state == ST_IDLE) && !swap;
    assign wr_fire  = wr_valid && wr_ready;

    // Logical colour -> physical slot lookup; illegal index/colour is dropped.
    always_comb begin
        wr_legal  = 1'b0;
        wr_phys   = '0;
        map_shift = 0;
        if ((32'(wr_led) < NUM_LEDS) && (wr_color != 2'd3)) begin
            map_shift = 6 * 32'(wr_led) + 4 - 2 * 32'(wr_color);
            wr_phys   = SLOT_W'(COLOR_MAP >> map_shift);
            wr_legal  = 32'(wr_phys) < NUM_SLOTS;
        end
    end

    // Banks, clear sequencer, commit/swap and brightness latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < int'(NUM_LEDS); l++) begin
                    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                        bank[b][l][s] <= '0;
                    end
                end
            end
            state          <= ST_IDLE;
            clr_idx        <= '0;
            front_sel      <= 1'b0;
            commit_pending <= 1'b0;
            bright_q       <= '1;
            wr_err         <= 1'b0;
        end else begin
            wr_err <= wr_fire && !wr_legal;
            if (wr_fire && wr_legal) begin
                bank[back_sel][wr_led][wr_phys] <= wr_value;
            end
            if (frame_start) begin
                bright_q <= brightness;
            end
            // A commit that lands on the swap cycle re-arms for the next frame.
            commit_pending <= (commit_pending && !swap) || commit;
            if (swap) begin
                front_sel <= ~front_sel;
            end
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                    end
                end
                ST_CLEAR: begin
                    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                        bank[back_sel][clr_idx][s] <= '0;
                    end
                    clr_idx <= clr_idx + 1'b1;
                    if (32'(clr_idx) == NUM_LEDS - 1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int l = 0; l < int'(NUM_LEDS); l++) begin
            raw[l] = (32'(rd_slot) < NUM_SLOTS) ? bank[front_sel][l][rd_slot] : '0;
        end
    end

    for (genvar l = 0; l < int'(NUM_LEDS); l++) begin : g_lane
        led_scale8 u_scale (
            .raw      (raw[l]),
            .scale    (bright_q),
            .scaled_c (scaled[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_values <= '0;
        end else begin
            for (int l = 0; l < int'(NUM_LEDS); l++) begin
                rd_values[l*VAL_W +: VAL_W] <= scaled[l];
            end
        end
    end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed self-checking bench for led_frame_buffer.
module tb_led_frame_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_led;
    logic [1:0]  wr_color;
    logic [7:0]  wr_value;
    logic        wr_err;
    logic        clear;
    logic        commit;
    logic        commit_pending;
    logic [7:0]  brightness;
    logic        frame_start;
    logic [1:0]  rd_slot;
    logic [87:0] rd_values;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    led_frame_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_led         (wr_led),
        .wr_color       (wr_color),
        .wr_value       (wr_value),
        .wr_err         (wr_err),
        .clear          (clear),
        .commit         (commit),
        .commit_pending (commit_pending),
        .brightness     (brightness),
        .frame_start    (frame_start),
        .rd_slot        (rd_slot),
        .rd_values      (rd_values)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] lane(input logic [87:0] v, input int l);
        return v[8*l +: 8];
    endfunction

    task automatic do_write(input logic [3:0] led, input logic [1:0] color, input logic [7:0] val);
        wr_valid = 1'b1; wr_led = led; wr_color = color; wr_value = val;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_swap();
        commit = 1'b1; tick(); commit = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); else pass_cnt++;
        chk_cnt++; if (rd_values !== 88'h0) $display("FAIL reset_rd_values got=%h exp=0", rd_values); else pass_cnt++;
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL reset_commit_pending got=%b exp=0", commit_pending); else pass_cnt++;
        chk_cnt++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err got=%b exp=0", wr_err); else pass_cnt++;
        rst = 1'b0; tick();
        chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL reset_release_wr_ready got=%b exp=1", wr_ready); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_write(4'd0, 2'd0, 8'hFF);
        chk_cnt++; if (wr_err !== 1'b0) $display("FAIL basic_wr_err got=%b exp=0", wr_err); else pass_cnt++;
        commit = 1'b1; tick(); commit = 1'b0;
        chk_cnt++; if (commit_pending !== 1'b1) $display("FAIL basic_pending_set got=%b exp=1", commit_pending); else pass_cnt++;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL basic_pending_clr got=%b exp=0", commit_pending); else pass_cnt++;
        rd_slot = 2'd0; tick();
        chk_cnt++; if (lane(rd_values, 0) !== 8'hFF) $display("FAIL basic_led0_red got=%h exp=ff", lane(rd_values, 0)); else pass_cnt++;
        // LED1 red maps to physical slot 2.
        do_write(4'd1, 2'd0, 8'hFF);
        do_swap();
        rd_slot = 2'd2; tick();
        chk_cnt++; if (lane(rd_values, 1) !== 8'hFF) $display("FAIL basic_led1_map got=%h exp=ff", lane(rd_values, 1)); else pass_cnt++;
        rd_slot = 2'd0; tick();
        chk_cnt++; if (lane(rd_values, 0) !== 8'h00) $display("FAIL basic_no_copy got=%h exp=00", lane(rd_values, 0)); else pass_cnt++;
    endtask

    task automatic test_no_commit();
        do_write(4'd7, 2'd1, 8'h40);
        rd_slot = 2'd0; tick();
        chk_cnt++; if (lane(rd_values, 7) !== 8'h00) $display("FAIL nocommit_hidden got=%h exp=00", lane(rd_values, 7)); else pass_cnt++;
        commit = 1'b1; tick(); commit = 1'b0;
        frame_start = 1'b1;
        chk_cnt++; if (commit_pending !== 1'b1) $display("FAIL nocommit_pending_before got=%b exp=1", commit_pending); else pass_cnt++;
        tick(); frame_start = 1'b0;
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL nocommit_pending_after got=%b exp=0", commit_pending); else pass_cnt++;
        tick();
        chk_cnt++; if (lane(rd_values, 7) !== 8'h40) $display("FAIL nocommit_led7 got=%h exp=40", lane(rd_values, 7)); else pass_cnt++;
        chk_cnt++; if (lane(rd_values, 0) !== 8'hFF) $display("FAIL nocommit_stale_led0 got=%h exp=ff", lane(rd_values, 0)); else pass_cnt++;
    endtask

    task automatic test_brightness();
        do_write(4'd2, 2'd0, 8'h80);
        commit = 1'b1; tick(); commit = 1'b0;
        brightness = 8'h7F; frame_start = 1'b1; tick(); frame_start = 1'b0;
        rd_slot = 2'd0; tick();
        chk_cnt++; if (lane(rd_values, 2) !== 8'h40) $display("FAIL bright_7f got=%h exp=40", lane(rd_values, 2)); else pass_cnt++;
        brightness = 8'h00; tick();
        chk_cnt++; if (lane(rd_values, 2) !== 8'h40) $display("FAIL bright_midframe got=%h exp=40", lane(rd_values, 2)); else pass_cnt++;
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        chk_cnt++; if (lane(rd_values, 2) !== 8'h00) $display("FAIL bright_zero got=%h exp=00", lane(rd_values, 2)); else pass_cnt++;
        brightness = 8'hFF; frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        chk_cnt++; if (lane(rd_values, 2) !== 8'h80) $display("FAIL bright_full got=%h exp=80", lane(rd_values, 2)); else pass_cnt++;
    endtask

    task automatic test_illegal();
        wr_valid = 1'b1; wr_led = 4'd11; wr_color = 2'd0; wr_value = 8'hAA;
        chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL illegal_accepted got=%b exp=1", wr_ready); else pass_cnt++;
        tick(); wr_valid = 1'b0;
        chk_cnt++; if (wr_err !== 1'b1) $display("FAIL illegal_led_err got=%b exp=1", wr_err); else pass_cnt++;
        tick();
        chk_cnt++; if (wr_err !== 1'b0) $display("FAIL illegal_led_pulse got=%b exp=0", wr_err); else pass_cnt++;
        do_write(4'd3, 2'd3, 8'hBB);
        chk_cnt++; if (wr_err !== 1'b1) $display("FAIL illegal_color_err got=%b exp=1", wr_err); else pass_cnt++;
        rd_slot = 2'd0; tick();
        chk_cnt++; if (wr_err !== 1'b0) $display("FAIL illegal_color_pulse got=%b exp=0", wr_err); else pass_cnt++;
        chk_cnt++; if (rd_values !== 88'h80_00_00) $display("FAIL illegal_front_s0 got=%h exp=%h", rd_values, 88'h80_00_00); else pass_cnt++;
        rd_slot = 2'd2; tick();
        chk_cnt++; if (rd_values !== 88'hFF_00) $display("FAIL illegal_front_s2 got=%h exp=%h", rd_values, 88'hFF_00); else pass_cnt++;
        do_swap();
        rd_slot = 2'd0; tick();
        chk_cnt++; if (rd_values !== 88'h40_00_00_00_00_00_00_FF) $display("FAIL illegal_back_s0 got=%h exp=%h", rd_values, 88'h40_00_00_00_00_00_00_FF); else pass_cnt++;
        rd_slot = 2'd3; tick();
        chk_cnt++; if (rd_values !== 88'h0) $display("FAIL slot3_zero got=%h exp=0", rd_values); else pass_cnt++;
    endtask

    task automatic test_clear();
        int low_cnt;
        low_cnt = 0;
        rd_slot = 2'd0;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            commit      = (i == 2);
            frame_start = (i == 5);
            if (wr_ready === 1'b1) break;
            low_cnt++;
            tick();
        end
        commit = 1'b0; frame_start = 1'b0;
        chk_cnt++; if (low_cnt !== 11) $display("FAIL clear_ready_low got=%0d exp=11", low_cnt); else pass_cnt++;
        chk_cnt++; if (commit_pending !== 1'b1) $display("FAIL clear_pending_held got=%b exp=1", commit_pending); else pass_cnt++;
        tick();
        chk_cnt++; if (rd_values !== 88'h40_00_00_00_00_00_00_FF) $display("FAIL clear_no_early_swap got=%h exp=%h", rd_values, 88'h40_00_00_00_00_00_00_FF); else pass_cnt++;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL clear_swap_pending got=%b exp=0", commit_pending); else pass_cnt++;
        for (int s = 0; s < 3; s++) begin
            rd_slot = 2'(s); tick();
            chk_cnt++; if (rd_values !== 88'h0) $display("FAIL clear_zero_slot%0d got=%h exp=0", s, rd_values); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [87:0] exp_v [3];
        exp_v[0] = 88'h40_55_00_11_00_00_00_FF;
        exp_v[1] = 88'h22_00_00_00_00;
        exp_v[2] = 88'h44_00_33_00_00_00_00;
        wr_valid = 1'b1;
        wr_led = 4'd4; wr_color = 2'd0; wr_value = 8'h11; tick();
        wr_color = 2'd1; wr_value = 8'h22; tick();
        wr_color = 2'd2; wr_value = 8'h33; tick();
        wr_led = 4'd6; wr_color = 2'd0; wr_value = 8'h44; tick();
        wr_color = 2'd2; wr_value = 8'h55; tick();
        wr_valid = 1'b0;
        do_swap();
        for (int s = 0; s < 3; s++) begin
            rd_slot = 2'(s); tick();
            chk_cnt++; if (rd_values !== exp_v[s]) $display("FAIL b2b_slot%0d got=%h exp=%h", s, rd_values, exp_v[s]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        brightness = 8'h10; frame_start = 1'b1; tick(); frame_start = 1'b0;
        brightness = 8'hFF;
        commit = 1'b1; tick(); commit = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        chk_cnt++; if (wr_ready !== 1'b0) $display("FAIL rstmid_wr_ready_in_rst got=%b exp=0", wr_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL rstmid_pending got=%b exp=0", commit_pending); else pass_cnt++;
        chk_cnt++; if (rd_values !== 88'h0) $display("FAIL rstmid_rd_values got=%h exp=0", rd_values); else pass_cnt++;
        chk_cnt++; if (dut.bright_q !== 8'hFF) $display("FAIL rstmid_bright_q got=%h exp=ff", dut.bright_q); else pass_cnt++;
        rst = 1'b0; tick();
        chk_cnt++; if (wr_ready !== 1'b1) $display("FAIL rstmid_wr_ready_after got=%b exp=1", wr_ready); else pass_cnt++;
        frame_start = 1'b1; rd_slot = 2'd1; tick(); frame_start = 1'b0;
        chk_cnt++; if (commit_pending !== 1'b0) $display("FAIL rstmid_no_swap got=%b exp=0", commit_pending); else pass_cnt++;
        tick();
        chk_cnt++; if (rd_values !== 88'h0) $display("FAIL rstmid_banks_zero got=%h exp=0", rd_values); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_led = '0; wr_color = '0; wr_value = '0;
        clear = 1'b0; commit = 1'b0; brightness = 8'hFF; frame_start = 1'b0; rd_slot = '0;
        test_reset();
        test_basic();
        test_no_commit();
        test_brightness();
        test_illegal();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
